// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Sequencer for the multiply-accumulate ALU
//             (result = a*b + c*d + e). Accepts one command at a time,
//             loads the ALU's five input registers from a single serial
//             operand stream through one-hot register enables, waits one
//             cycle for the ALU result to settle, captures it and offers it
//             on a valid/ready result port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n             clock, asynchronous active-low reset
//    cmd_valid/cmd_ready    command handshake; cmd_mode 0 = full MAC
//                           (a,b,c,d,e), 1 = add mode (a,b,c,d; e from a)
//    opnd_in/opnd_valid/    serial operand stream, one operand per
//    opnd_ready             handshake in the order a, b, c, d[, e]
//    alu_ops                broadcast of opnd_in to all five ALU lanes
//    alu_reg_en             ALU register load strobes
//    alu_f_add              latched command mode, steers ALU e-load to lane 0
//    alu_result             combinational result from the ALU
//    res_data/res_valid/    captured result and its handshake
//    res_ready
//    busy                   high whenever a command is in progress
//    op_count               number of results consumed (wraps)
// ============================================================================
module alu_seq #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_mode,
    input  logic [BUS_WIDTH-1:0]   opnd_in,
    input  logic                   opnd_valid,
    output logic                   opnd_ready,
    output logic [5*BUS_WIDTH-1:0] alu_ops,
    output logic [4:0]             alu_reg_en,
    output logic                   alu_f_add,
    input  logic [BUS_WIDTH-1:0]   alu_result,
    output logic [BUS_WIDTH-1:0]   res_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] k;          // index of the operand being loaded
    logic [2:0] k_nxt;
    logic [2:0] last_idx;

    // Add mode needs only four operands; e is taken from lane 0 together
    // with a, so the load phase ends one operand earlier.
    assign last_idx = alu_f_add ? 3'd3 : 3'd4;

    // The ALU captures the operand only where an enable is high, so a
    // plain broadcast is sufficient.
    assign alu_ops = {5{opnd_in}};

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        cmd_ready  = 1'b0;
        opnd_ready = 1'b0;
        res_valid  = 1'b0;
        alu_reg_en = 5'b00000;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = LOAD;
                    k_nxt     = 3'd0;
                end
            end
            LOAD: begin
                opnd_ready = 1'b1;
                if (opnd_valid) begin
                    // Enable fires on the handshake cycle itself so the ALU
                    // register loads on the same edge the operand is taken.
                    alu_reg_en = 5'b00001 << k;
                    if (alu_f_add && (k == 3'd0)) begin
                        alu_reg_en[4] = 1'b1;
                    end
                    if (k == last_idx) begin
                        state_nxt = EXEC;
                    end else begin
                        k_nxt = k + 3'd1;
                    end
                end
            end
            EXEC: begin
                // ALU result settles from the registers loaded last edge.
                state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= 3'd0;
            alu_f_add <= 1'b0;
            res_data  <= '0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            if ((state == IDLE) && cmd_valid) begin
                alu_f_add <= cmd_mode;
            end
            if (state == EXEC) begin
                res_data <= alu_result;
            end
            if ((state == RESP) && res_ready) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Sequencer that feeds the multiply-accumulate ALU (result = a·b + c·d + e) from a single serial operand stream. It accepts one command at a time and loads the ALU's five input registers one operand per handshake via one-hot register enables. It then waits one cycle for the ALU result to settle, captures the result, and presents it on a valid/ready output. It sits between the instruction/operand fetch logic and the ALU, and is the only driver of the ALU's `ops`, `reg_en` and `f_add` inputs.

## Interface
- `BUS_WIDTH`, 8, width of each operand and of the result.
- `CNT_WIDTH`, 16, width of the completed-operation counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_mode`  in  1  0 = full MAC (5 operands a,b,c,d,e); 1 = add mode (4 operands, e taken from a). Sampled at command handshake.
- `opnd_in`  in  BUS_WIDTH  serial operand data.
- `opnd_valid`  in  1  operand present.
- `opnd_ready`  out  1  operand accepted when `opnd_valid & opnd_ready`.
- `alu_ops`  out  5×BUS_WIDTH  to ALU `ops`; every lane carries `opnd_in` (broadcast).
- `alu_reg_en`  out  5  to ALU `reg_en`; one-hot (two-hot in mode 1) load strobes.
- `alu_f_add`  out  1  to ALU `f_add`; 1 makes the ALU's e register load from lane 0.
- `alu_result`  in  BUS_WIDTH  from ALU `result`.
- `res_data`  out  BUS_WIDTH  captured result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  CNT_WIDTH  number of results consumed; wraps modulo 2^CNT_WIDTH.

## Operation
- States: IDLE, LOAD, EXEC, RESP. Encoding is free.
- IDLE:
  - `cmd_ready`=1, `opnd_ready`=0.
  - On command handshake: latch `cmd_mode` into `alu_f_add`, clear the operand index k to 0, go to LOAD.
- LOAD:
  - `opnd_ready`=1, `cmd_ready`=0.
  - `alu_reg_en[k]` = `opnd_valid`; all other bits are 0, except in mode 1 where `alu_reg_en[4]` = `opnd_valid` while k=0.
  - On each operand handshake, k increments.
  - Last index is 4 in mode 0 and 3 in mode 1. The handshake at the last index goes to EXEC.
  - Operand order is fixed: a, b, c, d, then e (mode 0 only).
  - `opnd_valid` low stalls in place; `alu_reg_en` stays 0 during the stall.
- EXEC: one cycle. No enables and no handshakes. `res_data` <= `alu_result` at the end of the cycle; go to RESP.
- RESP:
  - `res_valid`=1 and `res_data` is held.
  - On result handshake: `op_count` += 1 (wraps), go to IDLE.
- `alu_f_add` holds the latched mode from command acceptance through RESP. It changes only on a command handshake.
- `alu_ops` is purely combinational broadcast of `opnd_in`. The ALU captures it only where `alu_reg_en` is high.
- Arithmetic is performed entirely by the ALU. The sequencer never modifies data.
- `cmd_valid` asserted outside IDLE is ignored (not accepted, not queued).
- `opnd_valid` outside LOAD is ignored and produces no enables.
- Reset (`rst_n`=0), at any time including mid-LOAD or RESP:
  - State goes immediately to IDLE and k to 0.
  - Outputs take these values: `alu_reg_en`=0, `alu_f_add`=0, `res_valid`=0, `res_data`=0, `op_count`=0, `busy`=0, `opnd_ready`=0.
  - `cmd_ready` is 1 once `rst_n` is high.
  - A partially loaded operation is discarded.

## Timing
- Command handshake in cycle 0.
- Operands in cycles 1..5 (mode 0) or 1..4 (mode 1), with no stalls.
- EXEC in cycle 6 (mode 0) or cycle 5 (mode 1).
- `res_valid` rises in cycle 7 (mode 0) or cycle 6 (mode 1).
- With `res_ready` held at 1, the next command can be accepted 1 cycle after the result handshake. Minimum period is 8 cycles (mode 0) or 7 cycles (mode 1).
- `alu_reg_en` is combinational from state, k and `opnd_valid`. The ALU registers update on the same edge as the operand handshake.
- `alu_result` is valid in EXEC because the last load edge precedes it.

## Test plan
- Mode 0:
  - Stimulus: command, then a=4, b=0x40, c=6, d=0x40, e=10 back-to-back, with the real ALU attached.
  - Required response: `res_data`=15 in cycle 7; `alu_reg_en` sequence 00001, 00010, 00100, 01000, 10000; `op_count`=1 after the result handshake.
- Mode 1:
  - Stimulus: command, then a=4, b=0x40, c=6, d=0x40.
  - Required response: first enable is 10001; `res_data`=9 in cycle 6; no fifth operand is accepted.
- Stalls:
  - Stimulus: `opnd_valid` low for 3 cycles between c and d; `res_ready` low for 4 cycles.
  - Required response: `alu_reg_en`=0 during the stall; `res_data` stable while waiting; `busy` high throughout; the result is still 15.
- Ignored inputs:
  - Stimulus: `cmd_valid` held high during LOAD/EXEC/RESP, with a different `cmd_mode`.
  - Required response: `cmd_ready`=0; `alu_f_add` unchanged; exactly one command accepted per result.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 after 2 operands, then release and run mode 0 with a=1, b=0x40, c=2, d=0x40, e=0.
  - Required response: all outputs at reset values immediately; `res_data`=1 with no residue from the aborted operation.
- Counter wrap:
  - Stimulus: CNT_WIDTH=2, run 5 operations.
  - Required response: `op_count` reads 1, 2, 3, 0, 1.
